// File: rtl/scc_ocm_sound.sv
// scc_ocm_sound: Konami SCC-compatible megarom mapper plus 5-channel wavetable synth on the OCM slot bus.
// Build option: define SCC_FREQ_RESET_EN so frequency writes restart that channel's counter and wave pointer.
module scc_ocm_sound (
   input  logic        clk21m,
   input  logic        reset,
   input  logic        req,
   output logic        ack,
   input  logic        wrt,
   input  logic [15:0] adr,
   output logic [7:0]  dbi,
   input  logic [7:0]  dbo,
   output logic        ramreq,
   output logic        ramwrt,
   output logic [20:0] ramadr,
   input  logic [7:0]  ramdbi,
   output logic [7:0]  ramdbo,
   output logic [14:0] wavl
);

   // Bus protocol: req is captured at edge k, decoded and answered at edge k+1 (ack or ramreq);
   // a RAM read samples ramdbi and acks at edge k+2, and req is dropped while that read is in flight.
   logic        r_req_q;
   logic        r_wrt_q;
   logic [15:0] r_adr_q;
   logic [7:0]  r_dbo_q;
   logic        r_rd_pend;
   logic        r_ack;
   logic [7:0]  r_dbi;
   logic        r_ramreq;
   logic        r_ramwrt;
   logic [20:0] r_ramadr;
   logic [7:0]  r_ramdbo;
   logic [7:0]  r_bank [0:3];

   logic [7:0]  r_wave [0:127];
   logic [11:0] r_freq [0:4];
   logic [3:0]  r_vol  [0:4];
   logic [4:0]  r_en;
   logic [11:0] r_cnt  [0:4];
   logic [4:0]  r_ptr  [0:4];
   logic [2:0]  r_div;
   logic [14:0] r_wavl;

   logic        w_page_hit;
   logic [1:0]  w_page;
   logic        w_bank_wr;
   logic        w_scc_sel;
   logic        w_ram_acc;
   logic        w_busy;
   logic        w_scc_wr;
   logic [7:0]  w_scc_rdata;
   logic        w_ce;
   logic [7:0]  w_smp  [0:4];
   logic [12:0] w_term [0:4];
   logic [14:0] w_sum;

   assign w_page_hit  = (r_adr_q[15:13] >= 3'd2) && (r_adr_q[15:13] <= 3'd5);
   assign w_page      = 2'(r_adr_q[15:13] - 3'd2);
   assign w_bank_wr   = r_wrt_q && (r_adr_q[12:11] == 2'b10);
   assign w_scc_sel   = (r_adr_q[15:11] == 5'b10011) && (r_bank[2][5:0] == 6'h3F);
   assign w_ram_acc   = w_page_hit && !w_bank_wr && !w_scc_sel;
   assign w_busy      = r_rd_pend || (r_req_q && w_ram_acc && !r_wrt_q);
   assign w_scc_wr    = r_req_q && w_page_hit && w_scc_sel && r_wrt_q;
   assign w_scc_rdata = r_adr_q[7] ? 8'hFF : r_wave[r_adr_q[6:0]];
   assign w_ce        = (r_div == 3'd5);

   always_ff @(posedge clk21m or posedge reset) begin
      if (reset) begin
         r_req_q   <= 1'b0;
         r_wrt_q   <= 1'b0;
         r_adr_q   <= '0;
         r_dbo_q   <= '0;
         r_rd_pend <= 1'b0;
         r_ack     <= 1'b0;
         r_dbi     <= '0;
         r_ramreq  <= 1'b0;
         r_ramwrt  <= 1'b0;
         r_ramadr  <= '0;
         r_ramdbo  <= '0;
         for (int p = 0; p < 4; p++) r_bank[p] <= 8'(p);
      end else begin
         r_req_q <= req && !w_busy;
         if (req && !w_busy) begin
            r_wrt_q <= wrt;
            r_adr_q <= adr;
            r_dbo_q <= dbo;
         end
         r_ack     <= 1'b0;
         r_ramreq  <= 1'b0;
         r_rd_pend <= 1'b0;
         if (r_rd_pend) begin
            r_dbi <= ramdbi;
            r_ack <= 1'b1;
         end
         if (r_req_q) begin
            if (w_ram_acc) begin
               r_ramreq <= 1'b1;
               r_ramwrt <= r_wrt_q;
               r_ramadr <= {r_bank[w_page], r_adr_q[12:0]};
               r_ramdbo <= r_dbo_q;
               if (r_wrt_q) r_ack <= 1'b1;
               else         r_rd_pend <= 1'b1;
            end else begin
               // Out-of-range pages, bank writes and SCC accesses all complete in one cycle.
               r_ack <= 1'b1;
               if (w_page_hit && w_bank_wr) r_bank[w_page] <= r_dbo_q;
               if (w_page_hit && w_scc_sel && !r_wrt_q) r_dbi <= w_scc_rdata;
            end
         end
      end
   end

   always_ff @(posedge clk21m or posedge reset) begin
      if (reset) begin
         r_div  <= '0;
         r_wavl <= '0;
         r_en   <= '0;
         for (int i = 0; i < 128; i++) r_wave[i] <= '0;
         for (int c = 0; c < 5; c++) begin
            r_freq[c] <= '0;
            r_vol[c]  <= '0;
            r_cnt[c]  <= '0;
            r_ptr[c]  <= '0;
         end
      end else begin
         r_div <= w_ce ? 3'd0 : r_div + 3'd1;
         if (w_ce) begin
            r_wavl <= w_sum;
            for (int c = 0; c < 5; c++) begin
               if (r_freq[c] >= 12'd9) begin
                  if (r_cnt[c] <= 12'd1) begin
                     r_cnt[c] <= r_freq[c];
                     r_ptr[c] <= r_ptr[c] + 5'd1;
                  end else begin
                     r_cnt[c] <= r_cnt[c] - 12'd1;
                  end
               end
            end
         end
         if (w_scc_wr) begin
            if (!r_adr_q[7]) begin
               r_wave[r_adr_q[6:0]] <= r_dbo_q;
            end else if (r_adr_q[7:5] == 3'b100) begin
               for (int c = 0; c < 5; c++) begin
                  if (r_adr_q[3:0] == 4'(2 * c)) begin
                     r_freq[c][7:0] <= r_dbo_q;
`ifdef SCC_FREQ_RESET_EN
                     r_cnt[c] <= {r_freq[c][11:8], r_dbo_q};
                     r_ptr[c] <= '0;
`endif
                  end
                  if (r_adr_q[3:0] == 4'(2 * c + 1)) begin
                     r_freq[c][11:8] <= r_dbo_q[3:0];
`ifdef SCC_FREQ_RESET_EN
                     r_cnt[c] <= {r_dbo_q[3:0], r_freq[c][7:0]};
                     r_ptr[c] <= '0;
`endif
                  end
                  if (r_adr_q[3:0] == 4'(10 + c)) r_vol[c] <= r_dbo_q[3:0];
               end
               if (r_adr_q[3:0] == 4'hF) r_en <= r_dbo_q[4:0];
            end
         end
      end
   end

   // Channels 4 and 5 both play wave table 3.
   always_comb begin
      w_sum = '0;
      for (int c = 0; c < 5; c++) begin
         w_smp[c]  = r_wave[{(c > 3) ? 2'd3 : 2'(c), r_ptr[c]}];
         w_term[c] = $signed({{5{w_smp[c][7]}}, w_smp[c]}) * $signed({9'd0, r_vol[c]});
         if (!r_en[c]) w_term[c] = '0;
         w_sum = w_sum + {{2{w_term[c][12]}}, w_term[c]};
      end
   end

   assign ack    = r_ack;
   assign dbi    = r_dbi;
   assign ramreq = r_ramreq;
   assign ramwrt = r_ramwrt;
   assign ramadr = r_ramadr;
   assign ramdbo = r_ramdbo;
   assign wavl   = r_wavl;

endmodule

// File: tb/tb_scc_ocm_sound.sv
// Directed bench for scc_ocm_sound: mapper decode, RAM timing, SCC registers, mixer output and reset.
module tb_scc_ocm_sound;

   logic        clk21m;
   logic        reset;
   logic        req;
   logic        ack;
   logic        wrt;
   logic [15:0] adr;
   logic [7:0]  dbi;
   logic [7:0]  dbo;
   logic        ramreq;
   logic        ramwrt;
   logic [20:0] ramadr;
   logic [7:0]  ramdbi;
   logic [7:0]  ramdbo;
   logic [14:0] wavl;

   int          n_vec;
   int          n_err;
   int          op_lat;
   logic [7:0]  op_rd;
   logic        op_ramreq;
   logic        op_ramwrt;
   logic [20:0] op_ramadr;
   logic [7:0]  op_ramdbo;
   logic        any_rr;
   int          t;
   logic [14:0] w1;

   scc_ocm_sound u_dut (
      .clk21m (clk21m),
      .reset  (reset),
      .req    (req),
      .ack    (ack),
      .wrt    (wrt),
      .adr    (adr),
      .dbi    (dbi),
      .dbo    (dbo),
      .ramreq (ramreq),
      .ramwrt (ramwrt),
      .ramadr (ramadr),
      .ramdbi (ramdbi),
      .ramdbo (ramdbo),
      .wavl   (wavl)
   );

   initial clk21m = 1'b0;
   always #5 clk21m = ~clk21m;

   // External RAM model: each byte reads back as its low address bits xor 3C.
   assign ramdbi = ramadr[7:0] ^ 8'h3C;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic bus_op(input logic w, input logic [15:0] a, input logic [7:0] d);
      @(negedge clk21m);
      req = 1'b1; wrt = w; adr = a; dbo = d;
      @(negedge clk21m);
      req = 1'b0; wrt = 1'b0;
      op_lat = 0; op_ramreq = 1'b0;
      for (int i = 1; i <= 6 && op_lat == 0; i++) begin
         @(negedge clk21m);
         if (ramreq) begin
            op_ramreq = 1'b1; op_ramadr = ramadr; op_ramwrt = ramwrt; op_ramdbo = ramdbo;
         end
         if (ack) begin
            op_lat = i; op_rd = dbi;
         end
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk21m);
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      reset = 1'b1; req = 1'b0; wrt = 1'b0; adr = '0; dbo = '0;
      wait_cyc(3);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_ramreq", 32'(ramreq), 0);
      chk("rst_ramadr", 32'(ramadr), 0);
      chk("rst_dbi", 32'(dbi), 0);
      chk("rst_wavl", 32'(wavl), 0);
      reset = 1'b0;
      wait_cyc(2);

      // SCC window enable and wave table load
      bus_op(1'b1, 16'h9000, 8'h3F);
      chk("bank2_wr_lat", 32'(op_lat), 1);
      chk("bank2_wr_noram", 32'(op_ramreq), 0);
      any_rr = 1'b0;
      for (int i = 0; i < 32; i++) begin
         bus_op(1'b1, 16'h9800 + 16'(i), (i < 16) ? 8'd127 : 8'd0);
         any_rr = any_rr | op_ramreq;
      end
      chk("wave_wr_noram", 32'(any_rr), 0);
      bus_op(1'b0, 16'h9800, 8'h00);
      chk("scc_rd_lat", 32'(op_lat), 1);
      chk("scc_rd_9800", 32'(op_rd), 32'h7F);
      chk("scc_rd_noram", 32'(op_ramreq), 0);
      bus_op(1'b0, 16'h9810, 8'h00);
      chk("scc_rd_9810", 32'(op_rd), 32'h00);
      bus_op(1'b0, 16'h9880, 8'h00);
      chk("scc_rd_reg_ff", 32'(op_rd), 32'hFF);

      // RAM reads and writes through the mapper
      bus_op(1'b0, 16'h4000, 8'h00);
      chk("rd4000_ramreq", 32'(op_ramreq), 1);
      chk("rd4000_ramadr", 32'(op_ramadr), 32'h000000);
      chk("rd4000_ramwrt", 32'(op_ramwrt), 0);
      chk("rd4000_lat", 32'(op_lat), 2);
      chk("rd4000_dbi", 32'(op_rd), 32'h3C);
      bus_op(1'b1, 16'h7000, 8'h05);
      chk("bank1_wr_noram", 32'(op_ramreq), 0);
      bus_op(1'b0, 16'h6123, 8'h00);
      chk("rd6123_ramadr", 32'(op_ramadr), 32'h00A123);
      chk("rd6123_dbi", 32'(op_rd), 32'h1F);
      bus_op(1'b1, 16'h4ABC, 8'h5A);
      chk("wr4abc_ramadr", 32'(op_ramadr), 32'h000ABC);
      chk("wr4abc_ramwrt", 32'(op_ramwrt), 1);
      chk("wr4abc_ramdbo", 32'(op_ramdbo), 32'h5A);
      chk("wr4abc_lat", 32'(op_lat), 1);
      bus_op(1'b0, 16'h0010, 8'h00);
      chk("page_out_lat", 32'(op_lat), 1);
      chk("page_out_noram", 32'(op_ramreq), 0);

      // SCC window closed: 9800 goes to RAM, SCC contents untouched
      bus_op(1'b1, 16'h9000, 8'h00);
      bus_op(1'b0, 16'h9800, 8'h00);
      chk("closed_ramreq", 32'(op_ramreq), 1);
      chk("closed_ramadr", 32'(op_ramadr), 32'h001800);
      chk("closed_lat", 32'(op_lat), 2);
      bus_op(1'b1, 16'h9000, 8'h3F);
      bus_op(1'b0, 16'h9800, 8'h00);
      chk("reopen_9800", 32'(op_rd), 32'h7F);

      // Channel 1 square tone: 127*15 = 1905, half period 16*254 enables of 6 clocks
      bus_op(1'b1, 16'h9880, 8'hFE);
      bus_op(1'b1, 16'h9881, 8'h00);
      bus_op(1'b1, 16'h988A, 8'h0F);
      bus_op(1'b1, 16'h988F, 8'h01);
      wait_cyc(30);
      chk("tone_high", 32'(wavl), 1905);
      t = 0;
      while (wavl != 15'd0 && t < 30000) begin @(negedge clk21m); t++; end
      chk("tone_low", 32'(wavl), 0);
      t = 0;
      while (wavl != 15'd1905 && t < 30000) begin @(negedge clk21m); t++; end
      chk("tone_half_period", 32'(t), 24384);

      // Disable, then freeze ch1 pointer with freq < 9 and a ramp table (vol 1 shows pointer)
      bus_op(1'b1, 16'h988F, 8'h00);
      wait_cyc(14);
      chk("disabled_zero", 32'(wavl), 0);
      bus_op(1'b1, 16'h9880, 8'h05);
      for (int i = 0; i < 32; i++) bus_op(1'b1, 16'h9800 + 16'(i), 8'(i));
      bus_op(1'b1, 16'h988A, 8'h01);
      bus_op(1'b1, 16'h988F, 8'h01);
      wait_cyc(14);
      w1 = wavl;
      chk("frozen_range", 32'(w1 < 15'd32), 1);
      wait_cyc(3000);
      chk("frozen_hold", 32'(wavl), 32'(w1));

      // Negative samples, shared table 3, mirror enable write, ignored A0+ write
      for (int i = 0; i < 32; i++) bus_op(1'b1, 16'h9820 + 16'(i), 8'h80);
      for (int i = 0; i < 32; i++) bus_op(1'b1, 16'h9860 + 16'(i), 8'hFD);
      bus_op(1'b1, 16'h988B, 8'h02);
      bus_op(1'b1, 16'h988D, 8'h01);
      bus_op(1'b1, 16'h988E, 8'h0F);
      bus_op(1'b1, 16'h989F, 8'h1A);
      wait_cyc(14);
      // -128*2 + -3*1 + -3*15 = -304 = 15'h7ED0
      chk("mix_negative", 32'(wavl), 32'h7ED0);
      bus_op(1'b1, 16'h98AF, 8'h1F);
      wait_cyc(14);
      chk("a0_write_ignored", 32'(wavl), 32'h7ED0);

      // Asynchronous reset in the middle of a RAM read
      @(negedge clk21m);
      req = 1'b1; wrt = 1'b0; adr = 16'h4000;
      @(negedge clk21m);
      req = 1'b0;
      @(negedge clk21m);
      chk("midrst_ramreq_up", 32'(ramreq), 1);
      #1 reset = 1'b1;
      #1;
      chk("midrst_ramreq", 32'(ramreq), 0);
      chk("midrst_ack", 32'(ack), 0);
      chk("midrst_wavl", 32'(wavl), 0);
      wait_cyc(2);
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
